// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read-side controller with a 2-entry skid buffer, burst framing and delivered-word count
module fifo_rd_ctrl #(
    parameter int data_width = 16,
    parameter int burst_len  = 4,
    parameter int cnt_width  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [cnt_width-1:0]  word_cnt,
    output logic                  ovf_err
);
    localparam int bw = burst_len > 1 ? $clog2(burst_len) : 1;
    localparam logic [bw-1:0] last_idx = bw'(burst_len - 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
    state_t                r_state;
    logic [1:0]            r_occ;
    logic                  r_pend;
    logic                  r_rst_d;
    logic                  r_ovf;
    logic [data_width-1:0] r_buf0;
    logic [data_width-1:0] r_buf1;
    logic [bw-1:0]         r_bcnt;
    logic [cnt_width-1:0]  r_word_cnt;
    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_base;
    logic [1:0]            w_occ_n;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = fifo_valid && r_pend;
    assign w_base     = r_occ - {1'b0, w_pop};
    assign w_occ_n    = w_base + {1'b0, w_push};
    // an in-flight read counts as occupied so the buffer can never overflow
    assign fifo_rd_en = !rst && !fifo_empty && ({1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_pop} <= 3'd1);
    assign out_valid  = r_occ != 2'd0;
    assign out_data   = r_buf0;
    assign out_last   = out_valid && r_bcnt == last_idx;
    assign busy       = r_state != IDLE;
    assign word_cnt   = r_word_cnt;
    assign ovf_err    = r_ovf;
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_pend     <= 1'b0;
            r_rst_d    <= 1'b1;
            r_ovf      <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_bcnt     <= '0;
            r_word_cnt <= '0;
        end else begin
            r_rst_d    <= 1'b0;
            r_occ      <= w_occ_n;
            r_pend     <= fifo_rd_en;
            if (w_pop) r_buf0 <= r_buf1;
            if (w_push && w_base == 2'd0) r_buf0 <= fifo_dout;
            if (w_push && w_base == 2'd1) r_buf1 <= fifo_dout;
            if (w_pop) r_bcnt <= r_bcnt == last_idx ? '0 : r_bcnt + 1'b1;
            r_word_cnt <= r_word_cnt + cnt_width'(w_pop);
            // a stale read return right after reset is dropped silently
            if (fifo_valid && !r_pend && !r_rst_d) r_ovf <= 1'b1;
            r_state    <= (w_occ_n == 2'd0 && !fifo_rd_en) ? IDLE :
                          (w_occ_n != 2'd0 && !out_ready) ? STALL : ACTIVE;
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench with a FIFO model; second instance covers cnt_width=4, burst_len=1
module tb_fifo_rd_ctrl;
    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_valid = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        out_ready = 1'b0;
    logic        fifo_rd_en, out_valid, out_last, busy, ovf_err;
    logic [15:0] out_data, word_cnt;
    logic        u1_rd_en, u1_valid, u1_last, u1_busy, u1_ovf;
    logic [15:0] u1_data;
    logic [3:0]  u1_word_cnt;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          bad;
    logic [15:0] q[$];
    logic [15:0] got[$];
    logic        lst[$];
    logic        lst1[$];
    int          pcyc[$];

    fifo_rd_ctrl u0 (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .word_cnt(word_cnt), .ovf_err(ovf_err)
    );

    fifo_rd_ctrl #(.data_width(16), .burst_len(1), .cnt_width(4)) u1 (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_dout(fifo_dout), .fifo_rd_en(u1_rd_en), .out_valid(u1_valid), .out_data(u1_data),
        .out_last(u1_last), .out_ready(out_ready), .busy(u1_busy), .word_cnt(u1_word_cnt), .ovf_err(u1_ovf)
    );

    always #5 rd_clk = ~rd_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic step(input logic rdy, input logic fe, input logic inj);
        logic rd;
        rd = fifo_rd_en;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            lst.push_back(out_last);
            lst1.push_back(u1_last);
            pcyc.push_back(cyc);
        end
        @(posedge rd_clk); #1;
        cyc++;
        fifo_valid = rd | inj;
        fifo_dout  = rd ? q.pop_front() : (inj ? 16'hbeef : 16'h0000);
        out_ready  = rdy;
        fifo_empty = fe || q.size() == 0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0; fifo_valid = 1'b0; fifo_empty = 1'b1;
        q.delete(); got.delete(); lst.delete(); lst1.delete(); pcyc.delete();
        @(posedge rd_clk); #1;
        @(posedge rd_clk); #1;
        rst = 1'b0; #1;
    endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) q.push_back(base + 16'(i));
        fifo_empty = 1'b0; #1;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int c;
        for (c = 0; c < budget && got.size() < n; c++) step(1'b1, 1'b0, 1'b0);
        checks++; if (got.size() < n) begin failures++; $display("FAIL %s_timeout got=%0d words exp=%0d", name, got.size(), n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; fifo_valid = 1'b0; fifo_empty = 1'b0; #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        @(posedge rd_clk); #1;
        @(posedge rd_clk); #1;
        rst = 1'b0; fifo_empty = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    endtask

    task automatic test_stream();
        do_reset();
        load(8, 16'h0001);
        checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL stream_rd_en got=%b exp=1", fifo_rd_en); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stream_fill got=%b/%b exp=0/1", out_valid, busy); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001) begin failures++; $display("FAIL stream_first got=%b/%h exp=1/0001", out_valid, out_data); end
        run_until(8, 40, "stream");
        bad = 0;
        for (int i = 0; i < 8; i++) if (got[i] !== 16'(i + 1)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stream_order got=%0d bad words exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (lst[i] !== (i % 4 == 3)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stream_last got=%0d bad flags exp=0", bad); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (lst1[i] !== 1'b1) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bl1_last got=%0d low flags exp=0", bad); end
        checks++; if (pcyc[7] - pcyc[0] != 7) begin failures++; $display("FAIL stream_b2b got=%0d cycles exp=7", pcyc[7] - pcyc[0]); end
        checks++; if (word_cnt !== 16'd8) begin failures++; $display("FAIL stream_word_cnt got=%0d exp=8", word_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        do_reset();
        load(6, 16'h0001);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (out_data !== 16'h0001 || out_valid !== 1'b1 || out_last !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_stable got=%0d unstable cycles exp=0", bad); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (q.size() != 4) begin failures++; $display("FAIL stall_reads got=%0d left exp=4", q.size()); end
        checks++; if (busy !== 1'b1 || got.size() != 0) begin failures++; $display("FAIL stall_busy got=%b/%0d exp=1/0", busy, got.size()); end
        run_until(6, 40, "stall");
        bad = 0;
        for (int i = 0; i < 6; i++) if (got[i] !== 16'(i + 1)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_order got=%0d bad words exp=0", bad); end
        checks++; if (word_cnt !== 16'd6) begin failures++; $display("FAIL stall_word_cnt got=%0d exp=6", word_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        load(1000, 16'h0001);
        for (int c = 0; c < 20000 && got.size() < 1000; c++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'b0);
        checks++; if (got.size() != 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", got.size()); end
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(i + 1) || lst[i] !== (i % 4 == 3)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_order got=%0d bad words exp=0", bad); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL rand_ovf got=%b exp=0", ovf_err); end
        checks++; if (word_cnt !== 16'd1000) begin failures++; $display("FAIL rand_word_cnt got=%0d exp=1000", word_cnt); end
        checks++; if (u1_word_cnt !== 4'd8) begin failures++; $display("FAIL rand_cnt4 got=%0d exp=8", u1_word_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        load(17, 16'h0100);
        run_until(17, 60, "wrap");
        checks++; if (u1_word_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt4 got=%0d exp=1", u1_word_cnt); end
        checks++; if (word_cnt !== 16'd17) begin failures++; $display("FAIL wrap_cnt16 got=%0d exp=17", word_cnt); end
        bad = 0;
        for (int i = 0; i < 17; i++) if (lst1[i] !== 1'b1 || got[i] !== 16'h0100 + 16'(i)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL wrap_bl1 got=%0d bad words exp=0", bad); end
    endtask

    task automatic test_ovf();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovf_dropped got=%b/%b exp=0/0", out_valid, busy); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        checks++; if (ovf_err !== 1'b1 || got.size() != 0) begin failures++; $display("FAIL ovf_sticky got=%b/%0d exp=1/0", ovf_err, got.size()); end
        do_reset();
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(10, 16'h0001);
        run_until(2, 20, "mid_pre");
        rst = 1'b1; out_ready = 1'b0; #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", fifo_rd_en); end
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0; q.delete(); fifo_empty = 1'b1; fifo_valid = 1'b1; fifo_dout = 16'hdead;
        got.delete(); lst.delete(); lst1.delete(); pcyc.delete(); #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_flush got=%b%b%b exp=000", out_valid, out_last, busy); end
        checks++; if (word_cnt !== 16'd0 || u1_word_cnt !== 4'd0) begin failures++; $display("FAIL mid_word_cnt got=%0d/%0d exp=0/0", word_cnt, u1_word_cnt); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (ovf_err !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b/%b exp=0/0", ovf_err, out_valid); end
        load(4, 16'h0050);
        run_until(4, 20, "mid_post");
        bad = 0;
        for (int i = 0; i < 4; i++) if (got[i] !== 16'h0050 + 16'(i) || lst[i] !== (i == 3)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_bcnt got=%0d bad words exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ovf();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
